regfile_access_ctrl: RTL and testbench

- Owns the register file's single write port and its debug read port.
- Arbitrates register writes between CPU writeback and an ecall/IO requester (for example, switch input into a0), with a starvation guard that stalls the CPU.
- Sequences the board debug readout: a debounced confirm button latches a register index from the switches, reads that register, and holds the value for display.

---
 rtl/regfile_access_ctrl_if.sv | 35 +++
 rtl/regfile_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - bus bundle for the register file access controller
interface regfile_access_ctrl_if;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        io_req;
  logic [4:0]  io_waddr;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic        cpu_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dbg_mode;
  logic        dbg_btn;
  logic [4:0]  dbg_sel;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [31:0] dbg_value;
  logic        dbg_valid;

  modport slave (
    input  cpu_we, cpu_waddr, cpu_wdata, io_req, io_waddr, io_wdata,
    input  dbg_mode, dbg_btn, dbg_sel, dbg_rdata,
    output io_ack, cpu_stall, rf_we, rf_waddr, rf_wdata,
    output dbg_raddr, dbg_value, dbg_valid
  );

  modport master (
    output cpu_we, cpu_waddr, cpu_wdata, io_req, io_waddr, io_wdata,
    output dbg_mode, dbg_btn, dbg_sel, dbg_rdata,
    input  io_ack, cpu_stall, rf_we, rf_waddr, rf_wdata,
    input  dbg_raddr, dbg_value, dbg_valid
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - register file write-port arbiter and debug readout sequencer
module regfile_access_ctrl #(
  parameter int MAX_WAIT        = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input logic                  clk,
  input logic                  rstn,
  regfile_access_ctrl_if.slave bus
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_STALL, W_ACK} wr_state_t;
  typedef enum logic {D_IDLE, D_READ} dbg_state_t;

  wr_state_t       wr_state;
  logic [WCW-1:0]  wait_cnt;
  logic [WCW-1:0]  cpu_next_cnt;
  logic            stall_due;
  logic            io_ack_q;
  logic            cpu_stall_q;
  logic            grant_io;
  logic            sel_we;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;

  always_comb begin
    grant_io = 1'b0;
    case (wr_state)
      W_IDLE, W_WAIT: grant_io = bus.io_req && !bus.cpu_we;
      W_STALL:        grant_io = 1'b1;
      default:        grant_io = 1'b0;
    endcase
    sel_we   = grant_io ? 1'b1 : bus.cpu_we;
    sel_addr = grant_io ? bus.io_waddr : bus.cpu_waddr;
    sel_data = grant_io ? bus.io_wdata : bus.cpu_wdata;
  end

  // The count after this CPU grant; a fresh conflict in IDLE is the first blocked cycle.
  assign cpu_next_cnt = (wr_state == W_IDLE) ? WCW'(1) : wait_cnt + WCW'(1);
  assign stall_due    = (cpu_next_cnt == WCW'(MAX_WAIT - 1));

  // Write port is held quiet while reset is asserted, even with requests pending.
  assign bus.rf_we     = rstn && sel_we && (sel_addr != 5'd0);
  assign bus.rf_waddr  = rstn ? sel_addr : 5'd0;
  assign bus.rf_wdata  = rstn ? sel_data : 32'd0;
  assign bus.io_ack    = io_ack_q;
  assign bus.cpu_stall = cpu_stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state    <= W_IDLE;
      wait_cnt    <= '0;
      io_ack_q    <= 1'b0;
      cpu_stall_q <= 1'b0;
    end else begin
      io_ack_q    <= 1'b0;
      cpu_stall_q <= 1'b0;
      case (wr_state)
        W_IDLE, W_WAIT: begin
          if (!bus.io_req) begin
            wr_state <= W_IDLE;
          end else if (!bus.cpu_we) begin
            wr_state <= W_ACK;
            io_ack_q <= 1'b1;
          end else begin
            wait_cnt <= cpu_next_cnt;
            if (stall_due) begin
              wr_state    <= W_STALL;
              cpu_stall_q <= 1'b1;
            end else begin
              wr_state <= W_WAIT;
            end
          end
        end
        W_STALL: begin
          wr_state <= W_ACK;
          io_ack_q <= 1'b1;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  logic [1:0]     btn_sync;
  logic [DCW-1:0] db_cnt;
  logic           db_level;
  logic           db_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_sync <= 2'b00;
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], bus.dbg_btn};
      db_prev  <= db_level;
      if (btn_sync[1] != db_level) begin
        if (db_cnt == DCW'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= btn_sync[1];
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DCW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  dbg_state_t  dbg_state;
  logic [4:0]  dbg_raddr_q;
  logic [31:0] dbg_value_q;
  logic        dbg_valid_q;

  assign bus.dbg_raddr = dbg_raddr_q;
  assign bus.dbg_value = dbg_value_q;
  assign bus.dbg_valid = dbg_valid_q;

  // Edge detection runs regardless of mode, so a button already held when mode rises never fires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_state   <= D_IDLE;
      dbg_raddr_q <= 5'd0;
      dbg_value_q <= 32'd0;
      dbg_valid_q <= 1'b0;
    end else begin
      dbg_valid_q <= 1'b0;
      if (!bus.dbg_mode) begin
        dbg_state   <= D_IDLE;
        dbg_value_q <= 32'd0;
      end else begin
        case (dbg_state)
          D_IDLE: begin
            if (db_level && !db_prev) begin
              dbg_raddr_q <= bus.dbg_sel;
              dbg_state   <= D_READ;
            end
          end
          default: begin
            dbg_value_q <= bus.dbg_rdata;
            dbg_valid_q <= 1'b1;
            dbg_state   <= D_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - directed bench for regfile_access_ctrl
module tb_regfile_access_ctrl;
  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad = 0;

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl #(.MAX_WAIT(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Register file read model: x3 holds the test pattern, others a tagged address.
  assign bus.dbg_rdata = (bus.dbg_raddr == 5'd3) ? 32'hDEADBEEF : (32'h1234_0000 | {27'd0, bus.dbg_raddr});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d,
                          input logic ack, input logic stall);
    chk({tag, ".rf_we"}, {31'd0, bus.rf_we}, {31'd0, we});
    if (we) begin
      chk({tag, ".rf_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, a});
      chk({tag, ".rf_wdata"}, bus.rf_wdata, d);
    end
    chk({tag, ".io_ack"}, {31'd0, bus.io_ack}, {31'd0, ack});
    chk({tag, ".cpu_stall"}, {31'd0, bus.cpu_stall}, {31'd0, stall});
  endtask

  task automatic watch_dbg(input int n, output int pulses, output logic [31:0] val);
    pulses = 0;
    val = 32'd0;
    repeat (n) begin
      next_cycle();
      if (bus.dbg_valid === 1'b1) begin
        pulses++;
        val = bus.dbg_value;
      end
    end
  endtask

  int          pulses;
  logic [31:0] val;

  initial begin
    rstn = 1'b0;
    bus.cpu_we = 0; bus.cpu_waddr = 0; bus.cpu_wdata = 0;
    bus.io_req = 0; bus.io_waddr = 0; bus.io_wdata = 0;
    bus.dbg_mode = 0; bus.dbg_btn = 0; bus.dbg_sel = 0;
    next_cycle();
    next_cycle();
    chk_port("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("reset.dbg_value", bus.dbg_value, 32'd0);
    chk("reset.dbg_valid", {31'd0, bus.dbg_valid}, 32'd0);
    chk("reset.dbg_raddr", {27'd0, bus.dbg_raddr}, 32'd0);
    rstn = 1'b1;

    // Uncontended IO write lands at once, ack next cycle
    next_cycle();
    bus.io_req = 1; bus.io_waddr = 5'd10; bus.io_wdata = 32'h5; #1;
    chk_port("io_free.c0", 1'b1, 5'd10, 32'h5, 1'b0, 1'b0);
    next_cycle();
    chk_port("io_free.c1", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    bus.io_req = 0;
    next_cycle();
    chk_port("io_free.c2", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Starved IO request: 3 CPU grants, stall with IO write, ack with CPU resuming
    bus.cpu_we = 1; bus.cpu_waddr = 5'd5; bus.cpu_wdata = 32'hA;
    bus.io_req = 1; bus.io_waddr = 5'd17; bus.io_wdata = 32'h1; #1;
    for (int i = 0; i < 3; i++) begin
      chk_port($sformatf("starve.cpu%0d", i), 1'b1, 5'd5, 32'hA, 1'b0, 1'b0);
      next_cycle();
    end
    chk_port("starve.stall", 1'b1, 5'd17, 32'h1, 1'b0, 1'b1);
    next_cycle();
    chk_port("starve.ack", 1'b1, 5'd5, 32'hA, 1'b1, 1'b0);
    bus.io_req = 0;
    next_cycle();
    chk_port("starve.after", 1'b1, 5'd5, 32'hA, 1'b0, 1'b0);

    // CPU write to x0 is suppressed
    bus.cpu_waddr = 5'd0; #1;
    chk_port("cpu_x0", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    bus.cpu_we = 0;

    // IO write to x0: no write, ack still pulses once
    next_cycle();
    bus.io_req = 1; bus.io_waddr = 5'd0; bus.io_wdata = 32'h77; #1;
    chk_port("io_x0.c0", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    next_cycle();
    chk_port("io_x0.c1", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    bus.io_req = 0;
    next_cycle();
    chk_port("io_x0.c2", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Request withdrawn in WAIT: no IO write, no ack
    bus.cpu_we = 1; bus.cpu_waddr = 5'd6; bus.cpu_wdata = 32'hB;
    bus.io_req = 1; bus.io_waddr = 5'd9; bus.io_wdata = 32'h9; #1;
    chk_port("drop.c0", 1'b1, 5'd6, 32'hB, 1'b0, 1'b0);
    next_cycle();
    bus.io_req = 0; #1;
    chk_port("drop.c1", 1'b1, 5'd6, 32'hB, 1'b0, 1'b0);
    next_cycle();
    bus.cpu_we = 0; #1;
    chk_port("drop.c2", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    next_cycle();
    chk_port("drop.c3", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Reset during STALL clears everything, no ack afterwards
    bus.cpu_we = 1; bus.cpu_waddr = 5'd4; bus.cpu_wdata = 32'hC;
    bus.io_req = 1; bus.io_waddr = 5'd12; bus.io_wdata = 32'h3;
    repeat (3) next_cycle();
    chk_port("rst_stall.pre", 1'b1, 5'd12, 32'h3, 1'b0, 1'b1);
    rstn = 1'b0; #1;
    chk_port("rst_stall.in", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_stall.rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_stall.rf_wdata", bus.rf_wdata, 32'd0);
    bus.io_req = 0; bus.cpu_we = 0;
    next_cycle();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk_port($sformatf("rst_stall.post%0d", i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    end

    // Debug: a 2-cycle bounce must not be accepted
    bus.dbg_mode = 1; bus.dbg_sel = 5'd3;
    next_cycle();
    bus.dbg_btn = 1;
    next_cycle();
    next_cycle();
    bus.dbg_btn = 0;
    watch_dbg(12, pulses, val);
    chk("dbg.bounce_pulses", pulses, 0);
    chk("dbg.bounce_value", bus.dbg_value, 32'd0);

    // Stable press captures x3 with a single valid pulse
    bus.dbg_btn = 1;
    watch_dbg(20, pulses, val);
    chk("dbg.press_pulses", pulses, 1);
    chk("dbg.press_value", val, 32'hDEADBEEF);
    chk("dbg.raddr", {27'd0, bus.dbg_raddr}, 32'd3);
    chk("dbg.hold_value", bus.dbg_value, 32'hDEADBEEF);

    // Release, select x7, press again
    bus.dbg_btn = 0;
    watch_dbg(12, pulses, val);
    chk("dbg.release_pulses", pulses, 0);
    bus.dbg_sel = 5'd7; bus.dbg_btn = 1;
    watch_dbg(20, pulses, val);
    chk("dbg.sel7_pulses", pulses, 1);
    chk("dbg.sel7_value", val, 32'h1234_0007);
    chk("dbg.sel7_raddr", {27'd0, bus.dbg_raddr}, 32'd7);
    bus.dbg_btn = 0;
    watch_dbg(12, pulses, val);

    // Mode drop clears the displayed value
    bus.dbg_mode = 0;
    next_cycle();
    chk("dbg.mode_off_value", bus.dbg_value, 32'd0);

    // Button held while mode rises must not trigger a read
    bus.dbg_btn = 1;
    watch_dbg(12, pulses, val);
    chk("dbg.mode0_pulses", pulses, 0);
    bus.dbg_mode = 1;
    watch_dbg(12, pulses, val);
    chk("dbg.held_pulses", pulses, 0);
    chk("dbg.held_value", bus.dbg_value, 32'd0);
    bus.dbg_btn = 0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
